// File: rtl/fb_paint_ctrl.sv
// fb_paint_ctrl: paints a clamped square brush, or clears the whole screen,
// into a framebuffer write port. Pixels are written only during blanking
// (display_on=0), so scanout keeps the framebuffer while the line is visible.
// Define FB_CLEAR_EN to enable the clear_req screen-clear operation. Without
// it, clear_req is ignored.
module fb_paint_ctrl #(
  parameter int unsigned RESOLUTION_H = 640,
  parameter int unsigned RESOLUTION_V = 480,
  parameter int unsigned HPOS_WIDTH   = 10,
  parameter int unsigned VPOS_WIDTH   = 10,
  parameter int unsigned BRUSH_SIZE   = 20,
  parameter int unsigned ADDR_WIDTH   = 19
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  paint_req,
  input  logic                  clear_req,
  input  logic [HPOS_WIDTH-1:0] brush_x,
  input  logic [VPOS_WIDTH-1:0] brush_y,
  input  logic [2:0]            brush_color,
  input  logic                  display_on,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic [2:0]            fb_wdata,
  output logic                  busy,
  output logic                  done
);

  // Coordinates carry one extra bit so that brush_x+BRUSH_SIZE cannot wrap.
  localparam int unsigned XW = HPOS_WIDTH + 1;
  localparam int unsigned YW = VPOS_WIDTH + 1;

  localparam logic [XW-1:0]         X_MAX = XW'(RESOLUTION_H - 1);
  localparam logic [YW-1:0]         Y_MAX = YW'(RESOLUTION_V - 1);
  localparam logic [XW-1:0]         BS_X  = XW'(BRUSH_SIZE);
  localparam logic [YW-1:0]         BS_Y  = YW'(BRUSH_SIZE);
  localparam logic [ADDR_WIDTH-1:0] H_A   = ADDR_WIDTH'(RESOLUTION_H);

`ifdef FB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state;
  logic            paint_q;
  logic            clear_q;
  logic [XW-1:0]   x0, x1, col;
  logic [YW-1:0]   y0, y1, row;
  logic [2:0]      color;

  logic            paint_edge;
  logic            clear_edge;
  logic [XW-1:0]   bx, bx_hi, px0, px1;
  logic [YW-1:0]   by, by_hi, py0, py1;
  logic [ADDR_WIDTH-1:0] pix_addr;

  // Request edge detection and the clamped brush box for the current inputs.
  always_comb begin
    paint_edge = paint_req && !paint_q;
    clear_edge = CLEAR_EN && clear_req && !clear_q;

    bx    = {1'b0, brush_x};
    bx_hi = bx + BS_X;
    px0   = (bx < BS_X) ? '0 : bx - BS_X;
    px1   = (bx_hi > X_MAX) ? X_MAX : bx_hi;

    by    = {1'b0, brush_y};
    by_hi = by + BS_Y;
    py0   = (by < BS_Y) ? '0 : by - BS_Y;
    py1   = (by_hi > Y_MAX) ? Y_MAX : by_hi;

    // Arithmetic modulo 2**ADDR_WIDTH gives the required truncation.
    pix_addr = ADDR_WIDTH'(row) * H_A + ADDR_WIDTH'(col);
  end

  // Operation FSM with registered write port and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      paint_q  <= 1'b0;
      clear_q  <= 1'b0;
      x0       <= '0;
      x1       <= '0;
      y0       <= '0;
      y1       <= '0;
      col      <= '0;
      row      <= '0;
      color    <= '0;
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      paint_q <= paint_req;
      clear_q <= clear_req;
      fb_we   <= 1'b0;
      done    <= 1'b0;

      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (clear_edge) begin
            x0    <= '0;
            x1    <= X_MAX;
            y0    <= '0;
            y1    <= Y_MAX;
            col   <= '0;
            row   <= '0;
            color <= 3'b000;
            busy  <= 1'b1;
            state <= FILL;
          end else if (paint_edge) begin
            x0    <= px0;
            x1    <= px1;
            y0    <= py0;
            y1    <= py1;
            col   <= px0;
            row   <= py0;
            color <= brush_color;
            busy  <= 1'b1;
            state <= FILL;
          end
        end

        FILL: begin
          if (!display_on) begin
            fb_we    <= 1'b1;
            fb_waddr <= pix_addr;
            fb_wdata <= color;
            if (col == x1) begin
              col <= x0;
              if (row == y1) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_paint_ctrl.sv
// Self-checking bench for fb_paint_ctrl using a box/row-major reference model.
module tb_fb_paint_ctrl;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int BS = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        paint_req = 1'b0;
  logic        clear_req = 1'b0;
  logic [9:0]  brush_x = '0;
  logic [9:0]  brush_y = '0;
  logic [2:0]  brush_color = '0;
  logic        display_on = 1'b0;
  logic        fb_we;
  logic [18:0] fb_waddr;
  logic [2:0]  fb_wdata;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [18:0] wr_addr[$];
  logic [2:0]  wr_data[$];
  int          done_cnt   = 0;
  int          we_in_disp = 0;
  logic        disp_prev  = 1'b0;

  fb_paint_ctrl #(
    .RESOLUTION_H(640),
    .RESOLUTION_V(480),
    .HPOS_WIDTH(10),
    .VPOS_WIDTH(10),
    .BRUSH_SIZE(20),
    .ADDR_WIDTH(19)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .paint_req(paint_req),
    .clear_req(clear_req),
    .brush_x(brush_x),
    .brush_y(brush_y),
    .brush_color(brush_color),
    .display_on(display_on),
    .fb_we(fb_we),
    .fb_waddr(fb_waddr),
    .fb_wdata(fb_wdata),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Capture every framebuffer write and done pulse away from the active edge.
  always @(negedge clk) begin
    if (fb_we) begin
      wr_addr.push_back(fb_waddr);
      wr_data.push_back(fb_wdata);
      if (disp_prev) we_in_disp++;
    end
    if (done) done_cnt++;
    disp_prev = display_on;
  end

  // Clamped box of a brush centred at b on an axis of 0..maxv.
  task automatic box(input int b, input int maxv, output int lo, output int hi);
    lo = (b < BS) ? 0 : b - BS;
    hi = (b + BS > maxv) ? maxv : b + BS;
  endtask

  // Index of the first captured write that differs from the row-major fill, or -1.
  function automatic int first_bad(input int x0, input int x1, input int y0,
                                   input int y1, input logic [2:0] c);
    int w;
    w = x1 - x0 + 1;
    for (int k = 0; k < wr_addr.size(); k++) begin
      int ea;
      ea = (y0 + k / w) * H + x0 + k % w;
      if (int'(wr_addr[k]) != ea || wr_data[k] !== c) return k;
    end
    return -1;
  endfunction

  task automatic clear_capture();
    wr_addr.delete();
    wr_data.delete();
    done_cnt   = 0;
    we_in_disp = 0;
  endtask

  task automatic set_brush(input int x, input int y, input logic [2:0] c);
    brush_x     = 10'(x);
    brush_y     = 10'(y);
    brush_color = c;
  endtask

  task automatic pulse_paint();
    @(posedge clk); #1 paint_req = 1'b1;
    @(posedge clk); #1 paint_req = 1'b0;
  endtask

  // Wait for done_cnt to reach target within maxc cycles, then settle.
  task automatic wait_ops(input int target, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    total++; if (fb_we !== 1'b0)  begin bad++; $display("FAIL reset_we got=%b want=0", fb_we); end
    total++; if (fb_waddr !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", fb_waddr); end
    total++; if (fb_wdata !== '0) begin bad++; $display("FAIL reset_data got=%0d want=0", fb_wdata); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_paint_center();
    bit ok;
    int fb;
    clear_capture();
    set_brush(320, 240, 3'b101);
    pulse_paint();
    wait_ops(1, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL center_timeout got=no_done want=done"); end
    total++; if (wr_addr.size() != 1681) begin bad++; $display("FAIL center_count got=%0d want=1681", wr_addr.size()); end
    if (wr_addr.size() > 0) begin
      total++; if (wr_addr[0] !== 19'd141100) begin bad++; $display("FAIL center_first got=%0d want=141100", wr_addr[0]); end
      total++; if (wr_addr[$] !== 19'd166740) begin bad++; $display("FAIL center_last got=%0d want=166740", wr_addr[$]); end
    end
    fb = first_bad(300, 340, 220, 260, 3'b101);
    total++; if (fb != -1) begin bad++; $display("FAIL center_order got_bad_index=%0d want=-1", fb); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL center_done got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL center_busy got=%b want=0", busy); end
  endtask

  task automatic test_clamp();
    bit ok;
    int fb, outside;
    clear_capture();
    set_brush(5, 470, 3'b011);
    pulse_paint();
    wait_ops(1, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_timeout got=no_done want=done"); end
    total++; if (wr_addr.size() != 780) begin bad++; $display("FAIL clamp_count got=%0d want=780", wr_addr.size()); end
    fb = first_bad(0, 25, 450, 479, 3'b011);
    total++; if (fb != -1) begin bad++; $display("FAIL clamp_order got_bad_index=%0d want=-1", fb); end
    outside = 0;
    foreach (wr_addr[k]) if (int'(wr_addr[k]) >= H * V) outside++;
    total++; if (outside != 0) begin bad++; $display("FAIL clamp_range got=%0d want=0", outside); end
  endtask

  task automatic test_display_pause();
    bit ok;
    int fb, n_before, n_after;
    clear_capture();
    set_brush(100, 100, 3'b110);
    pulse_paint();
    for (int i = 0; i < 2000 && wr_addr.size() < 300; i++) @(negedge clk);
    @(posedge clk); #1 display_on = 1'b1;
    n_before = wr_addr.size();
    repeat (800) @(posedge clk);
    #1 n_after = wr_addr.size();
    display_on = 1'b0;
    total++; if (n_after - n_before != 1) begin bad++; $display("FAIL pause_window got=%0d want=1", n_after - n_before); end
    wait_ops(1, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL pause_timeout got=no_done want=done"); end
    total++; if (we_in_disp != 0) begin bad++; $display("FAIL pause_we got=%0d want=0", we_in_disp); end
    total++; if (wr_addr.size() != 1681) begin bad++; $display("FAIL pause_count got=%0d want=1681", wr_addr.size()); end
    fb = first_bad(80, 120, 80, 120, 3'b110);
    total++; if (fb != -1) begin bad++; $display("FAIL pause_order got_bad_index=%0d want=-1", fb); end
  endtask

  task automatic test_both_edges();
    int fb;
    bit ok;
    clear_capture();
    set_brush(200, 300, 3'b111);
    @(posedge clk); #1 paint_req = 1'b1; clear_req = 1'b1;
    @(posedge clk); #1 paint_req = 1'b0; clear_req = 1'b0;
`ifdef FB_CLEAR_EN
    for (int i = 0; i < 5000 && wr_addr.size() < 2000; i++) @(negedge clk);
    total++; if (wr_addr.size() < 2000) begin bad++; $display("FAIL both_progress got=%0d want>=2000", wr_addr.size()); end
    fb = first_bad(0, H - 1, 0, V - 1, 3'b000);
    total++; if (fb != -1) begin bad++; $display("FAIL both_clear_order got_bad_index=%0d want=-1", fb); end
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    ok = 1'b1;
`else
    wait_ops(1, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL both_timeout got=no_done want=done"); end
    total++; if (wr_addr.size() != 1681) begin bad++; $display("FAIL both_count got=%0d want=1681", wr_addr.size()); end
    fb = first_bad(180, 220, 280, 320, 3'b111);
    total++; if (fb != -1) begin bad++; $display("FAIL both_paint_order got_bad_index=%0d want=-1", fb); end
`endif
  endtask

  task automatic test_reset_midfill();
    bit ok;
    int fb;
    clear_capture();
    set_brush(400, 200, 3'b010);
    pulse_paint();
    for (int i = 0; i < 2000 && wr_addr.size() < 100; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL rst_mid_we got=%b want=0", fb_we); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL rst_mid_done got=%b want=0", done); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_capture();
    repeat (100) @(negedge clk);
    total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL rst_quiet got=%0d want=0", wr_addr.size()); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rst_quiet_done got=%0d want=0", done_cnt); end

    // A request held high across reset release starts one operation.
    @(posedge clk); #1 paint_req = 1'b1; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_capture();
    wait_ops(1, 5000, ok);
    repeat (20) @(negedge clk);
    paint_req = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL held_timeout got=no_done want=done"); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL held_done got=%0d want=1", done_cnt); end
    fb = first_bad(380, 420, 180, 220, 3'b010);
    total++; if (fb != -1 || wr_addr.size() != 1681) begin
      bad++; $display("FAIL held_writes got_count=%0d bad_index=%0d want_count=1681", wr_addr.size(), fb);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int fb;
    clear_capture();
    set_brush(600, 20, 3'b001);
    pulse_paint();
    for (int i = 0; i < 2000 && wr_addr.size() < 200; i++) @(negedge clk);
    set_brush(50, 50, 3'b100);
    pulse_paint();
    wait_ops(1, 5000, ok);
    repeat (10) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=no_done want=done"); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done got=%0d want=1", done_cnt); end
    total++; if (wr_addr.size() != 41 * 41) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", wr_addr.size(), 41 * 41); end
    fb = first_bad(580, 620, 0, 40, 3'b001);
    total++; if (fb != -1) begin bad++; $display("FAIL b2b_order got_bad_index=%0d want=-1", fb); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      int bx, by, x0, x1, y0, y1, fb, lim;
      logic [2:0] c;
      clear_capture();
      bx = $urandom_range(0, H - 1);
      by = $urandom_range(0, V - 1);
      c  = 3'($urandom_range(0, 7));
      box(bx, H - 1, x0, x1);
      box(by, V - 1, y0, y1);
      set_brush(bx, by, c);
      pulse_paint();
      lim = 0;
      while (done_cnt == 0 && lim < 10000) begin
        @(posedge clk); #1 display_on = ($urandom_range(0, 99) < 35);
        lim++;
      end
      display_on = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (done_cnt != 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", t, done_cnt); end
      total++; if (wr_addr.size() != (x1 - x0 + 1) * (y1 - y0 + 1)) begin
        bad++; $display("FAIL rand%0d_count got=%0d want=%0d", t, wr_addr.size(), (x1 - x0 + 1) * (y1 - y0 + 1));
      end
      fb = first_bad(x0, x1, y0, y1, c);
      total++; if (fb != -1) begin bad++; $display("FAIL rand%0d_order got_bad_index=%0d want=-1", t, fb); end
      total++; if (we_in_disp != 0) begin bad++; $display("FAIL rand%0d_we_visible got=%0d want=0", t, we_in_disp); end
    end
  endtask

  initial begin
    test_reset();
    test_paint_center();
    test_clamp();
    test_display_pause();
    test_both_edges();
    test_reset_midfill();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
